fpnew_sdotp_rr_sched: RTL and testbench

- Round-robin scheduler that shares one fpnew_sdotp_multi_wrapper instance between NumReq independent requesters, e.g. the FP issue ports of several harts.
- Arbitrates requests and drives the datapath's reg_enable stage enables, using a valid/ID shadow pipeline for stall and bubble-collapse control.
- Routes each result back to the requester that issued it.
- Sits between the requester ports and the shared dot-product datapath.

---
 rtl/fpnew_pkg.sv | 59 +++++
 rtl/fpnew_rr_arb_onehot.sv | 31 +++
 rtl/fpnew_sdotp_rr_sched.sv | 150 +++++++++++++++
 tb/tb_fpnew_sdotp_rr_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FP types used by the dot-product scheduler and its datapath.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS      = 5;
  localparam int unsigned SDOTP_HART_ID_WIDTH = 34;
  localparam int unsigned SDOTP_LANE_WIDTH    = 64;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    SDOTP  = 4'd0,
    EXVSUM = 4'd1,
    VSUM   = 4'd2,
    ADD    = 4'd3,
    MUL    = 4'd4,
    FMADD  = 4'd5
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Bit width of one request bundle for a given lane width; the field
  // order matches sdotp_req_t so flat vectors can be cast to the struct.
  function automatic int unsigned sdotp_req_width(input int unsigned lane_width);
    return 3 * lane_width + NUM_FP_FORMATS * 3 + 3 + 4 + 1 + 3 + 3;
  endfunction

  typedef struct packed {
    logic [2:0][SDOTP_LANE_WIDTH-1:0]  operands;
    logic [NUM_FP_FORMATS-1:0][2:0]    is_boxed;
    roundmode_e                        rnd_mode;
    operation_e                        op;
    logic                              op_mod;
    fp_format_e                        src_fmt;
    fp_format_e                        dst_fmt;
  } sdotp_req_t;

endpackage

// File: rtl/fpnew_rr_arb_onehot.sv
// Combinational round-robin arbiter: first valid requester at or after ptr.
module fpnew_rr_arb_onehot #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdW-1:0]    ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdW-1:0]    idx,
  output logic              any
);

  logic [IdW-1:0] cand;

  // Wrapped search from ptr; idx falls back to ptr when nothing is valid.
  always_comb begin
    grant = '0;
    idx   = ptr;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdW'((32'(ptr) + off) % NumReq);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpnew_sdotp_rr_sched.sv
// Round-robin scheduler sharing one dot-product datapath among NumReq
// requesters. A valid/ID shadow of the datapath pipeline drives the stage
// enables (stall + bubble collapse) and routes results back to the issuer.
module fpnew_sdotp_rr_sched import fpnew_pkg::*; #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned NumPipeRegs = 3,
  parameter int unsigned LaneWidth   = 64,
  parameter logic [SDOTP_HART_ID_WIDTH-1:0] HartIdBase = '0,
  localparam int unsigned ReqW       = sdotp_req_width(LaneWidth),
  localparam int unsigned IdW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0][ReqW-1:0]        req_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  output logic [LaneWidth-1:0]               rsp_result_o,
  output status_t                            rsp_status_o,
  output logic [ReqW-1:0]                    dp_req_o,
  output logic                               dp_mask_o,
  output logic [SDOTP_HART_ID_WIDTH-1:0]     dp_hart_id_o,
  output logic [NumPipeRegs-1:0]             dp_reg_enable_o,
  input  logic [LaneWidth-1:0]               dp_result_i,
  input  status_t                            dp_status_i,
  input  logic                               dp_mask_i,
  output logic                               busy_o
);

  if (NumPipeRegs < 1) begin : g_bad_pipe
    $error("NumPipeRegs must be at least 1");
  end
  if (NumReq < 2) begin : g_bad_req
    $error("NumReq must be at least 2");
  end

  localparam int unsigned L    = NumPipeRegs - 1;
  localparam int unsigned CntW = $clog2(NumPipeRegs + 1);

  typedef logic [IdW-1:0] id_t;

  logic [NumPipeRegs-1:0] vld;
  logic [NumPipeRegs-1:0] en;
  id_t                    id [NumPipeRegs];
  id_t                    rr_ptr;
  id_t                    grant_idx;
  logic [NumReq-1:0]      grant_oh;
  logic                   any_valid;
  logic                   accept;
  logic                   out_ready;
  logic                   out_fire;
  logic [CntW-1:0]        cnt;

  fpnew_rr_arb_onehot #(
    .NumReq (NumReq)
  ) u_arb (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .grant (grant_oh),
    .idx   (grant_idx),
    .any   (any_valid)
  );

  // Stage enables ripple back from the output: an empty stage always loads.
  always_comb begin
    out_ready = rsp_ready_i[id[L]];
    en        = '0;
    en[L]     = ~vld[L] | out_ready;
    for (int unsigned k = 0; k < L; k++) begin
      en[L-1-k] = ~vld[L-1-k] | en[L-k];
    end
    if (rst_i) begin
      en = '1;
    end
  end

  // Request side handshakes and granted bundle towards the datapath.
  always_comb begin
    accept          = any_valid & en[0] & ~rst_i;
    req_ready_o     = rst_i ? '0 : (grant_oh & {NumReq{en[0]}});
    dp_req_o        = req_i[grant_idx];
    dp_mask_o       = accept;
    dp_hart_id_o    = HartIdBase + SDOTP_HART_ID_WIDTH'(grant_idx);
    dp_reg_enable_o = en;
  end

  // Response side: the last shadow stage names the owner of the result.
  always_comb begin
    out_fire     = vld[L] & out_ready & ~rst_i;
    rsp_valid_o  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = vld[L] & (id[L] == IdW'(i)) & ~rst_i;
    end
    rsp_result_o = dp_result_i;
    rsp_status_o = dp_status_i;
    busy_o       = (cnt != '0);
  end

  // Valid shadow mirrors the datapath mask pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld <= '0;
    end else begin
      if (en[0]) vld[0] <= accept;
      for (int unsigned k = 1; k < NumPipeRegs; k++) begin
        if (en[k]) vld[k] <= vld[k-1];
      end
    end
  end

  // Requester IDs travel alongside the valid bits; no reset needed.
  always_ff @(posedge clk_i) begin
    if (en[0]) id[0] <= grant_idx;
    for (int unsigned k = 1; k < NumPipeRegs; k++) begin
      if (en[k]) id[k] <= id[k-1];
    end
  end

  // Round-robin pointer moves past the winner on every accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (32'(grant_idx) == NumReq - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // In-flight counter: accept and response in one cycle cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      case ({accept, out_fire})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  a_cnt_matches_vld: assert property (@(posedge clk_i) disable iff (rst_i)
    $countones(vld) == 32'(cnt));

  a_mask_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
    dp_mask_i == vld[L]);

  a_ready_onehot: assert property (@(posedge clk_i) $onehot0(req_ready_o));

endmodule

// File: tb/tb_fpnew_sdotp_rr_sched.sv
// Directed bench for fpnew_sdotp_rr_sched with a simple datapath model.
module tb_fpnew_sdotp_rr_sched;
  import fpnew_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned NP = 3;
  localparam logic [SDOTP_HART_ID_WIDTH-1:0] HART_BASE = 34'h2_0000_0010;

  logic                             clk = 1'b0;
  logic                             rst;
  sdotp_req_t [NR-1:0]              req;
  logic [NR-1:0]                    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0]                      rsp_result;
  status_t                          rsp_status;
  sdotp_req_t                       dp_req;
  logic                             dp_mask_o;
  logic [SDOTP_HART_ID_WIDTH-1:0]   dp_hart_id;
  logic [NP-1:0]                    dp_en;
  logic [63:0]                      dp_result;
  status_t                          dp_status;
  logic                             dp_mask_i;
  logic                             busy;

  always #5 clk = ~clk;

  fpnew_sdotp_rr_sched #(
    .NumReq      (NR),
    .NumPipeRegs (NP),
    .LaneWidth   (64),
    .HartIdBase  (HART_BASE)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_i           (req),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .rsp_status_o    (rsp_status),
    .dp_req_o        (dp_req),
    .dp_mask_o       (dp_mask_o),
    .dp_hart_id_o    (dp_hart_id),
    .dp_reg_enable_o (dp_en),
    .dp_result_i     (dp_result),
    .dp_status_i     (dp_status),
    .dp_mask_i       (dp_mask_i),
    .busy_o          (busy)
  );

  // Datapath model: enable-gated pipeline returning operand 0 as result.
  logic        pm [NP];
  logic [63:0] pd [NP];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NP; k++) pm[k] <= 1'b0;
    end else begin
      if (dp_en[0]) begin
        pm[0] <= dp_mask_o;
        pd[0] <= dp_req.operands[0];
      end
      for (int k = 1; k < NP; k++) begin
        if (dp_en[k]) begin
          pm[k] <= pm[k-1];
          pd[k] <= pd[k-1];
        end
      end
    end
  end
  assign dp_mask_i = pm[NP-1];
  assign dp_result = pd[NP-1];
  assign dp_status = status_t'(pd[NP-1][4:0]);

  function automatic logic [63:0] tag(input int i);
    return 64'h0123_4567_89AB_CD00 | 64'(i + 8);
  endfunction

  function automatic int idx_of(input logic [NR-1:0] oh);
    for (int i = 0; i < NR; i++) if (oh[i]) return i;
    return 0;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic          rst;
    logic [NR-1:0] valid;
    logic [NR-1:0] rready;
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] exp_rsp;
    logic [NP-1:0] exp_en;
    logic          exp_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] rr,
                              input logic [3:0] er, input logic [3:0] es,
                              input logic [2:0] ee, input logic eb);
    vec_t x;
    x.rst = r; x.valid = v; x.rready = rr; x.exp_ready = er;
    x.exp_rsp = es; x.exp_en = ee; x.exp_busy = eb;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t r, input int n);
    rst = r.rst; req_valid = r.valid; rsp_ready = r.rready;
    @(negedge clk);
    chk($sformatf("row%0d req_ready", n), 64'(req_ready), 64'(r.exp_ready));
    chk($sformatf("row%0d rsp_valid", n), 64'(rsp_valid), 64'(r.exp_rsp));
    chk($sformatf("row%0d reg_enable", n), 64'(dp_en), 64'(r.exp_en));
    chk($sformatf("row%0d busy", n), 64'(busy), 64'(r.exp_busy));
    chk($sformatf("row%0d dp_mask", n), 64'(dp_mask_o), 64'(|r.exp_ready));
    if (r.exp_ready != '0)
      chk($sformatf("row%0d hart_id", n), 64'(dp_hart_id),
          64'(HART_BASE + 34'(idx_of(r.exp_ready))));
    if (r.exp_rsp != '0) begin
      chk($sformatf("row%0d result", n), rsp_result, tag(idx_of(r.exp_rsp)));
      chk($sformatf("row%0d status", n), 64'(rsp_status), 64'(tag(idx_of(r.exp_rsp)) & 64'h1F));
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      req[i]             = '0;
      req[i].operands[0] = tag(i);
      req[i].operands[1] = ~tag(i);
      req[i].op          = SDOTP;
      req[i].rnd_mode    = RNE;
      req[i].src_fmt     = FP8;
      req[i].dst_fmt     = FP16;
    end
    rst = 1'b1; req_valid = '0; rsp_ready = '1;
    step(); step();

    //            rst valid    rready   ready    rsp      en      busy
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 3'b111, 0));
    // single op from requester 2
    tbl.push_back(mk(0, 4'b0100, 4'b1111, 4'b0100, 4'b0000, 3'b111, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 0));
    // reset with pointer at 3, then fairness over 8 cycles
    tbl.push_back(mk(1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 3'b111, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0010, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0100, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0001, 4'b0010, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0010, 4'b0100, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0100, 4'b1000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 0));
    // backpressure on requester 1, bubble collapse, full stall, shift-through
    tbl.push_back(mk(1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b1101, 4'b0010, 4'b0000, 3'b111, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1100, 4'b1101, 4'b0100, 4'b0010, 3'b011, 1));
    tbl.push_back(mk(0, 4'b1100, 4'b1101, 4'b1000, 4'b0010, 3'b011, 1));
    tbl.push_back(mk(0, 4'b1100, 4'b1101, 4'b0000, 4'b0010, 3'b000, 1));
    tbl.push_back(mk(0, 4'b1100, 4'b1101, 4'b0000, 4'b0010, 3'b000, 1));
    tbl.push_back(mk(0, 4'b1100, 4'b1111, 4'b0100, 4'b0010, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b1111, 4'b1000, 4'b0100, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 0));
    // reset mid-flight discards three ops; requester 3 granted right after
    tbl.push_back(mk(1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 3'b111, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0010, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0100, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(1, 4'b1000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 3'b111, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 3'b111, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'b111, 0));

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

    // Pointer wrap and idle bundle selection (pointer starts at 0 here).
    rst = 1'b0; rsp_ready = '1;
    req_valid = 4'b0010; @(negedge clk);
    chk("wrap grant1", 64'(req_ready), 64'(4'b0010));
    chk("wrap hart1", 64'(dp_hart_id), 64'(HART_BASE + 34'd1));
    step();
    req_valid = 4'b0000; @(negedge clk);
    chk("idle ready", 64'(req_ready), 64'(0));
    chk("idle mask", 64'(dp_mask_o), 64'(0));
    chk("idle bundle", dp_req.operands[0], tag(2));
    step();
    req_valid = 4'b0001; @(negedge clk);
    chk("wrap grant0", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = 4'b0011; @(negedge clk);
    chk("wrap grant1b", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    for (int w = 0; w < 20 && busy; w++) step();
    chk("drain idle", 64'(busy), 64'(0));

    // Fill with no consumer ready, hold, then drain in issue order 2,3,0.
    begin
      logic [NR-1:0] fill_exp [3];
      fill_exp[0] = 4'b0100; fill_exp[1] = 4'b1000; fill_exp[2] = 4'b0001;
      rsp_ready = '0; req_valid = 4'b1111;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("fill%0d ready", c), 64'(req_ready), 64'(fill_exp[c]));
        step();
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("stall%0d en", c), 64'(dp_en), 64'(0));
        chk($sformatf("stall%0d ready", c), 64'(req_ready), 64'(0));
        chk($sformatf("stall%0d rsp", c), 64'(rsp_valid), 64'(4'b0100));
        step();
      end
      req_valid = '0; rsp_ready = '1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("out%0d rsp", c), 64'(rsp_valid), 64'(fill_exp[c]));
        chk($sformatf("out%0d result", c), rsp_result, tag(idx_of(fill_exp[c])));
        step();
      end
      @(negedge clk);
      chk("final busy", 64'(busy), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
